slave_load_ctrl: RTL and testbench
==================================

Name: slave_load_ctrl

Overview:
Read-side data path of the AHB slave; the load counterpart to the sub-word store merge logic. Accepts AHB read transfers and issues a single-cycle word read to the slave RAM. Waits a fixed RAM latency, then extracts the addressed byte, halfword or word. Returns the result on hrdata with the correct hreadyout wait states. Sits between the slave address decoder/bus interface and the synchronous RAM read port.

Parameters:
ADDR_W, 32, byte address width; RAM word address is ADDR_W-2 bits
RAM_LAT, 1, cycles from ram_rd_en sampled high to ram_rd_data valid; legal range 1..8

Ports:
hclk  in  1  clock, all logic on rising edge
hreset  in  1  asynchronous, active-high reset
hsel  in  1  slave select
htrans  in  2  AHB transfer type; NONSEQ=2'b10, SEQ=2'b11
hwrite  in  1  1=write, 0=read
hsize  in  3  000 byte, 001 half, 010 word; other values treated as word
haddr  in  ADDR_W  byte address
hready_in  in  1  bus-level HREADY
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data, zero-extended, right-justified to bit 0
ram_rd_en  out  1  one-cycle RAM read strobe
ram_addr  out  ADDR_W-2  word address, haddr[ADDR_W-1:2]
ram_rd_data  in  32  RAM read data

Behaviour:
- Reset (async): state=IDLE, hreadyout=1, hresp=0, hrdata=0, ram_rd_en=0, ram_addr=0, latency counter=0.
- Accept condition (cycle T): hsel & htrans[1] & ~hwrite & hready_in.
  - On accept, latch hsize, haddr[1:0] and word address.
- Writes, IDLE/BUSY transfers and hsel=0: no RAM access, hreadyout stays 1, hresp=0, hrdata holds its last value.
- States:
  - IDLE: wait for accept. Accept -> RD_ISSUE.
  - RD_ISSUE (T+1): ram_rd_en=1, ram_addr=latched word address, hreadyout=0. Next state is RD_WAIT, with counter loaded to RAM_LAT-1. If RAM_LAT=1, next state is RD_CAPT.
  - RD_WAIT: hreadyout=0, counter decrements each cycle; counter==0 -> RD_CAPT.
  - RD_CAPT (cycle T+1+RAM_LAT): hreadyout=0. hrdata is registered from the extracted ram_rd_data at the end of this cycle. -> RD_DONE.
  - RD_DONE (T+2+RAM_LAT): hreadyout=1, hrdata valid. A new accept in this cycle -> RD_ISSUE (back-to-back reads, no idle gap). Otherwise -> IDLE.
- Read data-phase wait states = RAM_LAT+1.
- Extraction:
  - Byte: hrdata = {24'b0, lane haddr[1:0]}; lane 0=[7:0], 1=[15:8], 2=[23:16], 3=[31:24].
  - Half: haddr[1]=0 -> [15:0], haddr[1]=1 -> [31:16], zero-extended.
  - Word or hsize>010: full 32 bits.
- Non-accept inputs during RD_ISSUE/RD_WAIT/RD_CAPT are ignored. hready_in is low there because this slave is stalling.
- ram_rd_en is asserted for exactly one cycle per accepted read. It is never asserted for writes.
- Reset asserted mid-read: immediate return to the reset values, no ram_rd_en pulse afterwards. The pending read is dropped.

Optional Feature:
SLV_MISALIGN_ERR_EN
- Defined: a misaligned read (half with haddr[0]=1, or word with haddr[1:0]!=0) issues no RAM read. It gets the AHB two-cycle ERROR response: cycle 1 hreadyout=0, hresp=1; cycle 2 hreadyout=1, hresp=1; hrdata=0. Then -> IDLE, or RD_ISSUE on a new accept in cycle 2.
- Undefined: the low address bits are forced aligned (half ignores haddr[0], word ignores haddr[1:0]). hresp is tied 0.

Test Plan:
- Reset: hreset=1 mid-RD_WAIT (RAM_LAT=3) -> next cycle hreadyout=1, hrdata=0, ram_rd_en=0, no further strobe.
- Word read, RAM_LAT=1, haddr=0x10, ram_rd_data=0xDEADBEEF -> ram_rd_en=1 at T+1 with ram_addr=0x4; hreadyout low T+1..T+2; T+3 hreadyout=1, hrdata=0xDEADBEEF.
- Byte reads with ram_rd_data=0xA1B2C3D4 -> haddr[1:0]=0..3 yield 0xD4, 0xC3, 0xB2, 0xA1. Half reads at haddr=0x2 -> 0x0000A1B2.
- Back-to-back: reads to 0x0 and 0x4 (RAM_LAT=2), second accepted in first RD_DONE -> exactly two ram_rd_en pulses. Data phases are 3 wait states each, with no idle cycle between.
- Write transfer and htrans=IDLE with hsel=1 -> hreadyout stays 1, ram_rd_en never asserted, hrdata unchanged.
- With SLV_MISALIGN_ERR_EN: half read at haddr=0x1 -> no ram_rd_en; hresp=1 for two cycles with hreadyout 0 then 1. Without the macro, the same read returns ram_rd_data[15:0].

Source files
------------

// File: rtl/slave_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// slave_load_ctrl_if
//   Bundles the AHB read-side handshake of the slave together with the
//   synchronous RAM read port that the load controller drives.
//
//   AHB side : hsel, htrans, hwrite, hsize, haddr, hready_in   (to slave)
//              hreadyout, hresp, hrdata                         (from slave)
//   RAM side : ram_rd_en, ram_addr                              (from slave)
//              ram_rd_data                                      (to slave)
//
//   modport slave  : view taken by slave_load_ctrl
//   modport master : view taken by the surrounding bus fabric / RAM model
// -----------------------------------------------------------------------------
interface slave_load_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              hsel;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [ADDR_W-1:0] haddr;
   logic              hready_in;
   logic              hreadyout;
   logic              hresp;
   logic [31:0]       hrdata;
   logic              ram_rd_en;
   logic [ADDR_W-3:0] ram_addr;
   logic [31:0]       ram_rd_data;

   modport slave (
      input  hsel, htrans, hwrite, hsize, haddr, hready_in, ram_rd_data,
      output hreadyout, hresp, hrdata, ram_rd_en, ram_addr
   );

   modport master (
      output hsel, htrans, hwrite, hsize, haddr, hready_in, ram_rd_data,
      input  hreadyout, hresp, hrdata, ram_rd_en, ram_addr
   );
endinterface

// File: rtl/slave_load_ctrl.sv
// -----------------------------------------------------------------------------
// slave_load_ctrl
//   Read-side data path of the AHB slave. An accepted read issues one word
//   read to the synchronous RAM, waits RAM_LAT cycles, extracts the addressed
//   byte / halfword / word (zero-extended, right-justified) and returns it on
//   hrdata with RAM_LAT+1 data-phase wait states. Writes, IDLE/BUSY transfers
//   and unselected cycles never touch the RAM.
//
//   Ports
//     hclk    : clock, rising edge
//     hreset  : asynchronous, active-high reset
//     bus     : slave_load_ctrl_if.slave (AHB handshake + RAM read port)
//
//   Parameters
//     ADDR_W  : byte address width (must match the interface instance)
//     RAM_LAT : cycles from ram_rd_en sampled high to ram_rd_data valid, 1..8
//
//   Optional feature (macro SLV_MISALIGN_ERR_EN)
//     Defined   : misaligned half/word reads get a two-cycle ERROR response,
//                 no RAM access, hrdata cleared.
//     Undefined : low address bits are ignored for half/word reads and
//                 hresp is tied low.
// -----------------------------------------------------------------------------
module slave_load_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input logic              hclk,
   input logic              hreset,
   slave_load_ctrl_if.slave bus
);

   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_CAPT,
      S_RD_DONE,
      S_ERR_1,
      S_ERR_2
   } state_t;

   state_t            state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [2:0]        size_q,   size_d;
   logic [1:0]        lane_q,   lane_d;
   logic [ADDR_W-3:0] waddr_q,  waddr_d;
   logic [31:0]       hrdata_q, hrdata_d;

   logic rd_req;
   logic can_accept;
   logic misaligned;

   // Only NONSEQ/SEQ reads with the bus ready start a transfer.
   assign rd_req = bus.hsel & ((bus.htrans == 2'b10) | (bus.htrans == 2'b11)) &
                   ~bus.hwrite & bus.hready_in;

`ifdef SLV_MISALIGN_ERR_EN
   // Any hsize other than byte/half is a word access.
   assign misaligned = ((bus.hsize == 3'b001) & bus.haddr[0]) |
                       ((bus.hsize[2:1] != 2'b00) & (bus.haddr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Half reads look only at lane[1] and word reads at neither, which is what
   // forces misaligned addresses onto the aligned container.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [2:0]  sz,
                                           input logic [1:0]  lo);
      logic [31:0] r;
      case (sz)
         3'b000: begin
            case (lo)
               2'd0:    r = {24'b0, w[7:0]};
               2'd1:    r = {24'b0, w[15:8]};
               2'd2:    r = {24'b0, w[23:16]};
               default: r = {24'b0, w[31:24]};
            endcase
         end
         3'b001:  r = lo[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // skips an assignment would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      size_d     = size_q;
      lane_d     = lane_q;
      waddr_d    = waddr_q;
      hrdata_d   = hrdata_q;
      can_accept = 1'b0;

      case (state_q)
         S_IDLE: can_accept = 1'b1;
         S_RD_ISSUE: begin
            cnt_d   = CNT_W'(RAM_LAT - 1);
            state_d = (RAM_LAT == 1) ? S_RD_CAPT : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Leave when the decremented count reaches zero, so RD_CAPT lands
            // exactly RAM_LAT cycles after RD_ISSUE.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_RD_CAPT;
         end
         S_RD_CAPT: begin
            hrdata_d = extract(bus.ram_rd_data, size_q, lane_q);
            state_d  = S_RD_DONE;
         end
         S_RD_DONE: begin
            state_d    = S_IDLE;
            can_accept = 1'b1;
         end
`ifdef SLV_MISALIGN_ERR_EN
         S_ERR_1: state_d = S_ERR_2;
         S_ERR_2: begin
            state_d    = S_IDLE;
            can_accept = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // The ready cycles (IDLE, RD_DONE, ERR_2) double as address phases, so
      // back-to-back reads need no idle gap.
      if (can_accept && rd_req) begin
         size_d  = bus.hsize;
         lane_d  = bus.haddr[1:0];
         waddr_d = bus.haddr[ADDR_W-1:2];
         if (misaligned) begin
            state_d  = S_ERR_1;
            hrdata_d = '0;
         end else begin
            state_d  = S_RD_ISSUE;
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         size_q   <= '0;
         lane_q   <= '0;
         waddr_q  <= '0;
         hrdata_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         lane_q   <= lane_d;
         waddr_q  <= waddr_d;
         hrdata_q <= hrdata_d;
      end
   end

   assign bus.hreadyout = (state_q == S_IDLE) | (state_q == S_RD_DONE) |
                          (state_q == S_ERR_2);
`ifdef SLV_MISALIGN_ERR_EN
   assign bus.hresp     = (state_q == S_ERR_1) | (state_q == S_ERR_2);
`else
   assign bus.hresp     = 1'b0;
`endif
   assign bus.ram_rd_en = (state_q == S_RD_ISSUE);
   assign bus.ram_addr  = waddr_q;
   assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_slave_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slave_load_ctrl
//   Three instances of slave_load_ctrl (RAM_LAT = 1, 2, 3) share one AHB
//   stimulus stream. Each lane has its own RAM latency pipe and a
//   transaction-level reference model that counts cycles since acceptance;
//   every lane's outputs are compared against its model on each falling edge.
//   A vector table, hand-written corner sequences and a random phase drive
//   the stimulus.
// -----------------------------------------------------------------------------
module tb_slave_load_ctrl;
   localparam int ADDR_W = 32;
   localparam int NL     = 3;

   logic        hclk   = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel   = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize  = 3'b010;
   logic [31:0] haddr  = '0;
   logic        hready_ext = 1'b1;

   logic [31:0] mem [16];

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic        l_ready [NL];
   logic        l_resp  [NL];
   logic        l_rden  [NL];
   logic [31:0] l_hrdata[NL];
   logic [29:0] l_raddr [NL];

   always #5 hclk = ~hclk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit model_misaligned(input logic [2:0] sz, input logic [1:0] lo);
`ifdef SLV_MISALIGN_ERR_EN
      if (sz == 3'd0) return 1'b0;
      if (sz == 3'd1) return lo[0];
      return lo != 2'd0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [2:0] sz,
                                                 input logic [1:0] lo);
      if (sz == 3'd0) return (w >> (8 * lo)) & 32'h0000_00FF;
      if (sz == 3'd1) return (w >> (16 * lo[1])) & 32'h0000_FFFF;
      return w;
   endfunction

   for (genvar g = 0; g < NL; g++) begin : g_lane
      localparam int L = g + 1;

      slave_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

      slave_load_ctrl #(.ADDR_W(ADDR_W), .RAM_LAT(L)) dut (
         .hclk  (hclk),
         .hreset(hreset),
         .bus   (bus)
      );

      // Reference model: age = cycles since acceptance (0 = idle).
      int          age = 0;
      logic        err = 1'b0;
      logic [2:0]  sz  = '0;
      logic [1:0]  lo  = '0;
      logic [29:0] wa  = '0;
      logic [31:0] exp_rd = '0;
      int          done_age;
      logic        m_ready, exp_resp, exp_rden;

      always_comb begin
         done_age = err ? 2 : L + 2;
         m_ready  = (age == 0) || (age == done_age);
         exp_resp = err && (age != 0);
         exp_rden = !err && (age == 1);
      end

      assign bus.hsel      = hsel;
      assign bus.htrans    = htrans;
      assign bus.hwrite    = hwrite;
      assign bus.hsize     = hsize;
      assign bus.haddr     = haddr;
      assign bus.hready_in = m_ready & hready_ext;

      always @(posedge hclk or posedge hreset) begin
         if (hreset) begin
            age <= 0; err <= 1'b0; exp_rd <= '0; wa <= '0; sz <= '0; lo <= '0;
         end else if (m_ready && hsel && htrans[1] && !hwrite && hready_ext) begin
            age <= 1;
            sz  <= hsize;
            lo  <= haddr[1:0];
            wa  <= haddr[31:2];
            err <= model_misaligned(hsize, haddr[1:0]);
            if (model_misaligned(hsize, haddr[1:0])) exp_rd <= '0;
         end else if (age != 0 && age < done_age) begin
            age <= age + 1;
            if (!err && (age + 1 == done_age)) exp_rd <= model_extract(mem[wa[3:0]], sz, lo);
         end else begin
            age <= 0;
         end
      end

      // RAM: data valid exactly L cycles after a sampled strobe, garbage otherwise.
      logic [31:0] pipe [L];
      always @(posedge hclk or posedge hreset) begin
         if (hreset) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
         end else begin
            pipe[0] <= bus.ram_rd_en ? mem[bus.ram_addr[3:0]] : $urandom;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
         end
      end
      assign bus.ram_rd_data = pipe[L-1];

      always @(negedge hclk) begin
         if (chk_en) begin
            check($sformatf("lane%0d_outputs", g),
                  {29'b0, bus.hreadyout, bus.hresp, bus.ram_rd_en, bus.hrdata},
                  {29'b0, m_ready, exp_resp, exp_rden, exp_rd});
            if (exp_rden) check($sformatf("lane%0d_ram_addr", g), 64'(bus.ram_addr), 64'(wa));
         end
      end

      assign l_ready[g]  = bus.hreadyout;
      assign l_resp[g]   = bus.hresp;
      assign l_rden[g]   = bus.ram_rd_en;
      assign l_hrdata[g] = bus.hrdata;
      assign l_raddr[g]  = bus.ram_addr;
   end

   task automatic next_cycle();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive_idle();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = '0;
   endtask

   task automatic drive_read(input logic [2:0] s, input logic [31:0] a);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = s; haddr = a;
   endtask

   typedef struct {
      string       name;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int          pulses;
      logic [7:0]  rdy_seq;
      logic [31:0] h0 [NL];

      vecs[0] = '{"word_0x10",  3'b010, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{"byte_lane0", 3'b000, 32'h00, 32'hA1B2C3D4, 32'h000000D4};
      vecs[2] = '{"byte_lane1", 3'b000, 32'h01, 32'hA1B2C3D4, 32'h000000C3};
      vecs[3] = '{"byte_lane2", 3'b000, 32'h02, 32'hA1B2C3D4, 32'h000000B2};
      vecs[4] = '{"byte_lane3", 3'b000, 32'h03, 32'hA1B2C3D4, 32'h000000A1};
      vecs[5] = '{"half_hi",    3'b001, 32'h02, 32'hA1B2C3D4, 32'h0000A1B2};
      vecs[6] = '{"half_lo",    3'b001, 32'h20, 32'h5566F00D, 32'h0000F00D};
      vecs[7] = '{"size_111",   3'b111, 32'h08, 32'h01234567, 32'h01234567};
`ifdef SLV_MISALIGN_ERR_EN
      vecs[8] = '{"half_mis",   3'b001, 32'h01, 32'hA1B2C3D4, 32'h00000000};
      vecs[9] = '{"word_mis",   3'b010, 32'h13, 32'hCAFEF00D, 32'h00000000};
`else
      vecs[8] = '{"half_mis",   3'b001, 32'h01, 32'hA1B2C3D4, 32'h0000C3D4};
      vecs[9] = '{"word_mis",   3'b010, 32'h13, 32'hCAFEF00D, 32'hCAFEF00D};
`endif

      for (int i = 0; i < 16; i++) mem[i] = $urandom;

      // Reset state
      repeat (2) @(negedge hclk);
      for (int k = 0; k < NL; k++)
         check($sformatf("reset_lane%0d", k),
               {l_ready[k], l_resp[k], l_rden[k], l_hrdata[k], l_raddr[k]},
               {1'b1, 1'b0, 1'b0, 32'h0, 30'h0});
      next_cycle();
      hreset = 1'b0;
      chk_en = 1'b1;

      // Table of single reads
      foreach (vecs[i]) begin
         mem[vecs[i].addr[5:2]] = vecs[i].data;
         drive_read(vecs[i].sz, vecs[i].addr);
         next_cycle();
         drive_idle();
         repeat (6) next_cycle();
         for (int k = 0; k < NL; k++)
            check($sformatf("%s_lane%0d", vecs[i].name, k), 64'(l_hrdata[k]), 64'(vecs[i].exp));
      end

      // Word read, RAM_LAT=1: strobe and wait-state timing
      mem[4] = 32'hDEADBEEF;
      drive_read(3'b010, 32'h10);
      next_cycle();
      drive_idle();
      @(negedge hclk);
      check("w1_issue", {l_rden[0], l_ready[0], l_raddr[0]}, {1'b1, 1'b0, 30'h4});
      next_cycle();
      @(negedge hclk);
      check("w1_capt_ready", 64'(l_ready[0]), 64'd0);
      next_cycle();
      @(negedge hclk);
      check("w1_done", {l_ready[0], l_hrdata[0]}, {1'b1, 32'hDEADBEEF});
      repeat (4) next_cycle();

      // Back-to-back reads on the RAM_LAT=2 lane
      mem[0] = 32'h11112222;
      mem[1] = 32'h33334444;
      pulses  = 0;
      rdy_seq = '0;
      drive_read(3'b010, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         next_cycle();
         if (k == 4) drive_read(3'b010, 32'h4);
         else        drive_idle();
         @(negedge hclk);
         rdy_seq = {rdy_seq[6:0], l_ready[1]};
         if (l_rden[1]) pulses++;
         if (k == 4) check("b2b_first_data",  64'(l_hrdata[1]), 64'h11112222);
         if (k == 8) check("b2b_second_data", 64'(l_hrdata[1]), 64'h33334444);
      end
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_ready_seq", 64'(rdy_seq), 64'b00010001);
      next_cycle();
      drive_idle();
      repeat (5) next_cycle();

      // Writes, IDLE/BUSY, unselected and hready_in low: no RAM access
      for (int k = 0; k < NL; k++) h0[k] = l_hrdata[k];
      for (int s = 0; s < 6; s++) begin
         hsize = 3'b010; haddr = 32'h14; hready_ext = 1'b1;
         case (s)
            0: begin hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; end
            1: begin hsel = 1'b1; htrans = 2'b11; hwrite = 1'b1; end
            2: begin hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0; end
            3: begin hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0; end
            4: begin hsel = 1'b0; htrans = 2'b10; hwrite = 1'b0; end
            default: begin hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hready_ext = 1'b0; end
         endcase
         next_cycle();
         @(negedge hclk);
         for (int k = 0; k < NL; k++)
            check($sformatf("noacc%0d_lane%0d", s, k),
                  {l_ready[k], l_rden[k], l_hrdata[k]}, {1'b1, 1'b0, h0[k]});
      end
      hready_ext = 1'b1;
      drive_idle();
      next_cycle();

      // Misaligned half read at 0x1
      mem[0] = 32'hA1B2C3D4;
      drive_read(3'b001, 32'h1);
      next_cycle();
      drive_idle();
`ifdef SLV_MISALIGN_ERR_EN
      @(negedge hclk);
      check("mis_err1", {l_ready[0], l_resp[0], l_rden[0]}, 3'b010);
      next_cycle();
      @(negedge hclk);
      check("mis_err2", {l_ready[0], l_resp[0], l_rden[0], l_hrdata[0]}, {3'b110, 32'h0});
      next_cycle();
      @(negedge hclk);
      check("mis_after", {l_ready[0], l_resp[0]}, 2'b10);
`else
      repeat (6) next_cycle();
      check("mis_aligned_half", 64'(l_hrdata[0]), 64'h0000C3D4);
`endif
      repeat (4) next_cycle();

      // Reset in the middle of a RAM_LAT=3 read
      drive_read(3'b010, 32'h8);
      next_cycle();
      drive_idle();
      next_cycle();
      hreset = 1'b1;
      #1;
      check("rst_mid_read", {l_ready[2], l_rden[2], l_hrdata[2]}, {1'b1, 1'b0, 32'h0});
      next_cycle();
      hreset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge hclk);
         for (int k = 0; k < NL; k++) if (l_rden[k]) pulses++;
         next_cycle();
      end
      check("rst_no_strobe", 64'(pulses), 64'd0);

      // Random traffic against the per-lane models
      for (int c = 0; c < 800; c++) begin
         hsel       = ($urandom_range(0, 3) != 0);
         htrans     = 2'($urandom_range(0, 3));
         hwrite     = ($urandom_range(0, 9) < 3);
         hsize      = 3'($urandom_range(0, 7));
         haddr      = 32'($urandom_range(0, 63));
         hready_ext = ($urandom_range(0, 9) != 0);
         hreset     = ($urandom_range(0, 199) == 0);
         next_cycle();
      end

      hreset     = 1'b0;
      hready_ext = 1'b1;
      drive_idle();
      repeat (6) next_cycle();
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
